// File: rtl/memshare_rqst_sched_if.sv
// Request/grant/register-file bundle between the share-request source,
// the request scheduler and the shift-control register file.
interface memshare_rqst_sched_if #(
    parameter int unsigned SHARE_GROUP_SIZE = 5,
    parameter int unsigned RF_DEPTH         = 8
);
    localparam int unsigned N  = SHARE_GROUP_SIZE;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned AW = $clog2(RF_DEPTH);

    logic [N-1:0]  share_rqstFlag_i;
    logic          rqst_valid_i;
    logic          rqst_ready_o;
    logic          grant_valid_o;
    logic [IW-1:0] grant_idx_o;
    logic [N-1:0]  grant_onehot_o;
    logic          grant_ready_i;
    logic          rf_wr_en_o;
    logic [AW-1:0] rf_wr_addr_o;
    logic [IW-1:0] rf_wr_data_o;
    logic          round_done_o;
    logic          rf_wrap_o;

    modport slave (
        input  share_rqstFlag_i, rqst_valid_i, grant_ready_i,
        output rqst_ready_o, grant_valid_o, grant_idx_o, grant_onehot_o,
               rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, round_done_o, rf_wrap_o
    );

    modport master (
        output share_rqstFlag_i, rqst_valid_i, grant_ready_i,
        input  rqst_ready_o, grant_valid_o, grant_idx_o, grant_onehot_o,
               rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, round_done_o, rf_wrap_o
    );
endinterface

// File: rtl/memshare_rqst_sched.sv
// Serialises one round of share-request flags into fixed-priority grants on
// the shared memory port and logs each granted index into the shift-control RF.
module memshare_rqst_sched #(
    parameter int unsigned SHARE_GROUP_SIZE = 5,
    parameter int unsigned RF_DEPTH         = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    memshare_rqst_sched_if.slave  bus
);
    localparam int unsigned N  = SHARE_GROUP_SIZE;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned AW = $clog2(RF_DEPTH);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  pend, pend_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic          done_q, done_nxt;
    logic          wrap_q, wrap_nxt;
    logic [IW-1:0] low_idx;
    logic          low_found;
    logic [N-1:0]  low_mask;
    logic          accept;

    // Fixed priority: lowest pending index wins
    always_comb begin
        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend[i] && !low_found) begin
                low_idx   = IW'(i);
                low_found = 1'b1;
            end
        end
    end

    assign low_mask = N'(1) << low_idx;
    assign accept   = (state == SERVE) && bus.grant_ready_i;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            wr_ptr <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            wr_ptr <= wr_ptr_nxt;
            done_q <= done_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        wr_ptr_nxt = wr_ptr;
        done_nxt   = 1'b0;
        wrap_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rqst_valid_i) begin
                    // An empty vector still closes a round
                    if (|bus.share_rqstFlag_i) begin
                        pend_nxt  = bus.share_rqstFlag_i;
                        state_nxt = SERVE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (accept) begin
                    pend_nxt   = pend & ~low_mask;
                    wr_ptr_nxt = wr_ptr + AW'(1);
                    wrap_nxt   = (wr_ptr == AW'(RF_DEPTH - 1));
                    if ((pend & ~low_mask) == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rqst_ready_o   = (state == IDLE);
    assign bus.grant_valid_o  = (state == SERVE);
    assign bus.grant_idx_o    = low_idx;
    assign bus.grant_onehot_o = (state == SERVE) ? low_mask : '0;
    assign bus.rf_wr_en_o     = accept;
    assign bus.rf_wr_addr_o   = wr_ptr;
    assign bus.rf_wr_data_o   = low_idx;
    assign bus.round_done_o   = done_q;
    assign bus.rf_wrap_o      = wrap_q;
endmodule

// File: tb/tb_memshare_rqst_sched.sv
// Directed and random checks of memshare_rqst_sched against a queue-based round model.
module tb_memshare_rqst_sched;
    localparam int unsigned N     = 5;
    localparam int unsigned DEPTH = 8;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    memshare_rqst_sched_if #(.SHARE_GROUP_SIZE(N), .RF_DEPTH(DEPTH)) bus ();

    memshare_rqst_sched #(.SHARE_GROUP_SIZE(N), .RF_DEPTH(DEPTH)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a round is an ascending queue of requestor indices
    bit busy;
    int q[$];
    int wp;
    bit exp_done;
    bit exp_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 1'b0; q.delete(); wp = 0; exp_done = 1'b0; exp_wrap = 1'b0;
    endtask

    task automatic model_step();
        bit nd, nw;
        nd = 1'b0; nw = 1'b0;
        if (!busy && bus.rqst_valid_i) begin
            if (bus.share_rqstFlag_i == '0) nd = 1'b1;
            else begin
                for (int k = 0; k < int'(N); k++)
                    if (bus.share_rqstFlag_i[k]) q.push_back(k);
                busy = 1'b1;
            end
        end else if (busy && bus.grant_ready_i) begin
            if (wp == int'(DEPTH) - 1) nw = 1'b1;
            wp = (wp + 1) % int'(DEPTH);
            void'(q.pop_front());
            if (q.size() == 0) begin busy = 1'b0; nd = 1'b1; end
        end
        exp_done = nd; exp_wrap = nw;
    endtask

    task automatic check_outputs();
        int ei;
        ei = busy ? q[0] : 0;
        chk("rqst_ready",  32'(bus.rqst_ready_o),   32'(!busy));
        chk("grant_valid", 32'(bus.grant_valid_o),  32'(busy));
        chk("grant_idx",   32'(bus.grant_idx_o),    32'(ei));
        chk("grant_onehot",32'(bus.grant_onehot_o), busy ? (32'd1 << ei) : 32'd0);
        chk("rf_wr_en",    32'(bus.rf_wr_en_o),     32'(busy && bus.grant_ready_i === 1'b1));
        chk("rf_wr_addr",  32'(bus.rf_wr_addr_o),   32'(wp));
        if (busy && bus.grant_ready_i === 1'b1)
            chk("rf_wr_data", 32'(bus.rf_wr_data_o), 32'(ei));
        chk("round_done",  32'(bus.round_done_o),   32'(exp_done));
        chk("rf_wrap",     32'(bus.rf_wrap_o),      32'(exp_wrap));
    endtask

    // One cycle: check before the edge, advance the model at the edge
    task automatic tick();
        @(negedge sys_clk);
        check_outputs();
        @(posedge sys_clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic send(input logic [N-1:0] f);
        int n;
        bit acc;
        n = 0; acc = 1'b0;
        bus.share_rqstFlag_i = f;
        bus.rqst_valid_i     = 1'b1;
        while (!acc && n < 20) begin
            acc = !busy;
            tick();
            n++;
        end
        chk("send_timeout", 32'(acc), 32'd1);
        bus.rqst_valid_i     = 1'b0;
        bus.share_rqstFlag_i = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.grant_ready_i = 1'b1;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        model_reset();
        bus.share_rqstFlag_i = 5'b11111;
        bus.rqst_valid_i     = 1'b1;
        bus.grant_ready_i    = 1'b1;
        // Inputs must be ignored while reset is held
        tick(); tick();
        rst = 1'b0;
        bus.rqst_valid_i     = 1'b0;
        bus.share_rqstFlag_i = '0;
        tick();

        // Basic round: grants 1,2,4 at addr 0..2
        bus.grant_ready_i = 1'b1;
        send(5'b10110);
        chk("first_grant_idx", 32'(bus.grant_idx_o), 32'd1);
        drain();
        chk("round_done_after_basic", 32'(bus.round_done_o), 32'd1);

        // Backpressure: idx 0 holds for 3 cycles, no writes
        send(5'b00011);
        bus.grant_ready_i = 1'b0;
        repeat (3) tick();
        chk("bp_hold_idx", 32'(bus.grant_idx_o), 32'd0);
        drain();

        // Back-to-back: new vector presented while round_done is high
        chk("b2b_done_high", 32'(bus.round_done_o), 32'd1);
        send(5'b10000);
        chk("b2b_grant_idx", 32'(bus.grant_idx_o), 32'd4);
        drain();

        // Zero vector: only a round_done pulse, pointer unchanged
        send(5'b00000);
        tick();
        chk("zero_wr_addr", 32'(bus.rf_wr_addr_o), 32'd6);

        // Three more grants take the pointer through 7 and wrap to 0
        send(5'b11100);
        drain();
        chk("wrap_ptr", 32'(bus.rf_wr_addr_o), 32'd1);
        tick();

        // Async reset mid-SERVE after one accepted grant
        send(5'b11100);
        bus.grant_ready_i = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        bus.share_rqstFlag_i = 5'b10101;
        bus.rqst_valid_i     = 1'b1;
        tick(); tick();
        bus.rqst_valid_i     = 1'b0;
        bus.share_rqstFlag_i = '0;
        rst = 1'b0;
        tick();
        send(5'b01000);
        chk("post_reset_addr", 32'(bus.rf_wr_addr_o), 32'd0);
        drain();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.rqst_valid_i     = 1'($urandom_range(0, 1));
            bus.share_rqstFlag_i = N'($urandom_range(0, 31));
            bus.grant_ready_i    = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
